// File: rtl/calc_pkg.sv
// Shared types and constants for the calc_sched arbitrated add/sub front end.
package calc_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

endpackage

// File: rtl/calc_addsub.sv
// Combinational ripple add/subtract; result is {carry, WIDTH-bit sum}.
module calc_addsub
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    output logic [WIDTH:0]   result_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    always_comb begin
        b_eff = b_i;
        unique case (op_i)
            OP_ADD:  b_eff = b_i;
            // Negate first so B=0 yields a zero carry rather than the A+~B+1 carry.
            OP_SUB:  b_eff = ~b_i + WIDTH'(1);
            default: b_eff = b_i;
        endcase
        carry = '0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = a_i[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_eff[i]) | (carry[i] & (a_i[i] ^ b_eff[i]));
        end
        result_o = {carry[WIDTH], sum};
    end

endmodule

// File: rtl/calc_sched.sv
// Round-robin arbitrated front end for the shared add/sub unit (IDLE -> EXEC -> RESP).
// Optional op counter output ops_done enabled by defining CALC_SCHED_STATS_EN.
module calc_sched
    import calc_pkg::*;
#(
    parameter int unsigned  WIDTH = WIDTH_DEFAULT,
    parameter int unsigned  NREQ  = 2,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_result
`ifdef CALC_SCHED_STATS_EN
    ,
    output logic [15:0]           ops_done
`endif
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             op_q, op_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH:0]   rsp_result_q, rsp_result_d;

    logic [WIDTH:0]   alu_result;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;

    // First valid requester searching upward from last_grant+1, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(last_grant_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    calc_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i      (opa_q),
        .b_i      (opb_q),
        .op_i     (op_q),
        .result_o (alu_result)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        gid_d        = gid_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        req_ready    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    opa_d   = req_a[grant_idx*WIDTH +: WIDTH];
                    opb_d   = req_b[grant_idx*WIDTH +: WIDTH];
                    op_d    = req_op[grant_idx];
                    gid_d   = grant_idx;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_result_d = alu_result;
                rsp_id_d     = gid_q;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    last_grant_d = rsp_id_q;
                    rsp_valid_d  = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CALC_SCHED_STATS_EN
    logic [15:0] ops_done_q, ops_done_d;

    always_comb begin
        ops_done_d = ops_done_q;
        if (rsp_valid_q && rsp_ready) begin
            ops_done_d = ops_done_q + 16'd1;
        end
    end

    assign ops_done = ops_done_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= OP_ADD;
            gid_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
`ifdef CALC_SCHED_STATS_EN
            ops_done_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            gid_q        <= gid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
`ifdef CALC_SCHED_STATS_EN
            ops_done_q   <= ops_done_d;
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: doc/calc_sched.md
Name: calc_sched

Overview:
- Arbitrated, sequenced front end for the 4-bit add/subtract datapath.
- Up to NREQ requesters present operand pairs plus an op code over valid/ready; the block grants one requester at a time (round-robin), runs the operation through a single shared add/sub unit, and returns a registered 5-bit result tagged with the requester ID.
- Sits between requester blocks and the shared arithmetic resource; the only path to it.

Parameters:
- WIDTH, 4, operand width; result is WIDTH+1 bits.
- NREQ, 2, number of requesters (2..8); ID width IDW = $clog2(NREQ).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_op  in  NREQ  0 = add, 1 = subtract.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the served requester.
- rsp_result  out  WIDTH+1  {carry, WIDTH-bit sum/difference}.

Behaviour:
- Reset (rst_n=0 at clk edge), regardless of state:
  - state=IDLE; rsp_valid=0; rsp_id=0; rsp_result=0; req_ready=0.
  - last_grant=NREQ-1, so requester 0 has top priority after reset.
  - Reset mid-EXEC or mid-RESP discards the operation; no response is issued.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational.
  - If any req_valid, the grant g is the first asserted index searching from last_grant+1, wrapping modulo NREQ. req_ready[g]=1 in that cycle only.
  - On that edge, capture a/b/op/g into operand registers and go to EXEC.
  - No valid: stay in IDLE, req_ready=0.
- EXEC (1 cycle): drive captured operands into the add/sub unit; register its output into rsp_result and g into rsp_id; go to RESP.
- RESP:
  - rsp_valid=1; rsp_result and rsp_id held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: last_grant<=rsp_id, rsp_valid<=0, go to IDLE.
  - req_ready=0 throughout RESP and EXEC.
- Latency: acceptance edge to rsp_valid high is 2 cycles. Minimum 3 cycles per operation (no overlap).
- Requester rules: payload must be stable while req_valid=1. Dropping req_valid before grant is legal and is simply not served.
- Arithmetic, modulo 2^WIDTH:
  - add: rsp_result = A + B, zero-extended to WIDTH+1 (bit WIDTH = carry).
  - sub: tc = (~B + 1) truncated to WIDTH bits; rsp_result = A + tc, bit WIDTH = carry out.
  - Hence B=0 gives {0, A}. For B≠0, carry=1 iff A>=B.
- Round-robin boundaries:
  - All requesters continuously valid are served strictly in rotation.
  - A lone requester is served back-to-back every 3 cycles.
  - The pointer updates only on a completed response handshake.

Optional Feature:
- Macro CALC_SCHED_STATS_EN.
- Defined: adds output port ops_done, 16 bits. It resets to 0 on rst_n=0, increments by 1 on each rsp handshake, and wraps 0xFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package calc_pkg:
  - state enum {S_IDLE, S_EXEC, S_RESP};
  - op constants OP_ADD=1'b0, OP_SUB=1'b1;
  - default WIDTH constant.
- Sub-module calc_addsub (parameter WIDTH): purely combinational ripple add/subtract with the width and carry rules above, instantiated once.
- Arbitration and FSM stay in calc_sched.

Test Plan:
- Reset then req_valid=01, A0=4'h7, B0=4'h5, op=add, rsp_ready=1 -> req_ready=01 for one cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=5'h0C.
- Sub cases on requester 1, expected rsp_result:
  - A=3, B=5 -> 5'h0E.
  - A=9, B=4 -> 5'h15.
  - A=6, B=0 -> 5'h06.
  - Add A=F, B=F -> 5'h1E.
- Both requesters valid continuously for 4 operations after reset -> rsp_id sequence 0,1,0,1; each grant is exactly 3 cycles apart with rsp_ready=1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable; req_ready=0 throughout; release -> returns to IDLE next edge.
- Assert rst_n=0 during EXEC and during RESP -> next cycle rsp_valid=0, state IDLE, no response for the aborted request; next grant goes to requester 0.
- With CALC_SCHED_STATS_EN defined, after 3 completed ops ops_done=3. Preload to 0xFFFF via 65535 ops (or force) -> next handshake gives 0.
